// File: rtl/sample_packer.sv
// rtl/sample_packer.sv - packs two 14-bit channels into 32-bit words through a 16-entry FWFT FIFO
// Define PACKER_DROP_COUNT_EN to build the saturating drop counter; otherwise o_drop_count is 0.
module sample_packer (
  input  logic        i_sys_clk,
  input  logic        i_reset,
  input  logic [13:0] i_data_in_a,
  input  logic [13:0] i_data_in_b,
  input  logic        i_data_valid_in,
  input  logic        i_capture_en,
  input  logic        i_clear,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic        o_out_valid,
  output logic [4:0]  o_fifo_count,
  output logic        o_overflow,
  output logic [15:0] o_drop_count
);

  logic [31:0] r_mem [16];
  logic [3:0]  r_rd_ptr;
  logic [3:0]  r_wr_ptr;
  logic [4:0]  r_count;
  logic        r_overflow;
  logic        r_gap_pending;
  logic [1:0]  r_seq;

  logic        w_empty;
  logic        w_full;
  logic        w_strobe;
  logic        w_rd;
  logic        w_wr;
  logic        w_drop;
  logic [31:0] w_word;

  assign w_empty  = (r_count == 5'd0);
  assign w_full   = (r_count == 5'd16);
  assign w_strobe = i_data_valid_in & i_capture_en;
  assign w_rd     = ~w_empty & i_out_ready;
  // A read in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_wr     = w_strobe & (~w_full | w_rd);
  assign w_drop   = w_strobe & w_full & ~w_rd;
  assign w_word   = {r_seq, i_data_in_a, 1'b1, r_gap_pending, i_data_in_b};

  always_ff @(posedge i_sys_clk) begin
    if (w_wr && !i_clear) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr      <= 4'd0;
      r_wr_ptr      <= 4'd0;
      r_count       <= 5'd0;
      r_overflow    <= 1'b0;
      r_gap_pending <= 1'b0;
      r_seq         <= 2'd0;
    end else if (i_clear) begin
      r_rd_ptr      <= 4'd0;
      r_wr_ptr      <= 4'd0;
      r_count       <= 5'd0;
      r_overflow    <= 1'b0;
      r_gap_pending <= 1'b0;
      r_seq         <= 2'd0;
    end else begin
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 4'd1;
      end
      if (w_wr) begin
        r_wr_ptr      <= r_wr_ptr + 4'd1;
        r_seq         <= r_seq + 2'd1;
        r_gap_pending <= 1'b0;
      end
      if (w_drop) begin
        r_overflow    <= 1'b1;
        r_gap_pending <= 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PACKER_DROP_COUNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      r_drop_count <= 16'd0;
    end else if (i_clear) begin
      r_drop_count <= 16'd0;
    end else if (w_drop && r_drop_count != 16'hFFFF) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign o_drop_count = r_drop_count;
`else
  assign o_drop_count = 16'd0;
`endif

  // Memory is not reset, so the head is masked while reset is held.
  assign o_out_data   = i_reset ? 32'd0 : r_mem[r_rd_ptr];
  assign o_out_valid  = ~w_empty;
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_sample_packer.sv
// tb/tb_sample_packer.sv - directed and randomized checks of sample_packer against a queue model
module tb_sample_packer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [13:0] i_data_in_a;
  logic [13:0] i_data_in_b;
  logic        i_data_valid_in;
  logic        i_capture_en;
  logic        i_clear;
  logic        i_out_ready;
  logic [31:0] o_out_data;
  logic        o_out_valid;
  logic [4:0]  o_fifo_count;
  logic        o_overflow;
  logic [15:0] o_drop_count;

  always #5 clk = ~clk;

  sample_packer dut (
    .i_sys_clk       (clk),
    .i_reset         (i_reset),
    .i_data_in_a     (i_data_in_a),
    .i_data_in_b     (i_data_in_b),
    .i_data_valid_in (i_data_valid_in),
    .i_capture_en    (i_capture_en),
    .i_clear         (i_clear),
    .i_out_ready     (i_out_ready),
    .o_out_data      (o_out_data),
    .o_out_valid     (o_out_valid),
    .o_fifo_count    (o_fifo_count),
    .o_overflow      (o_overflow),
    .o_drop_count    (o_drop_count)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] q[$];
  int          m_seq;
  logic        m_gap;
  logic        m_ovf;
  int          m_drops;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_drops();
`ifdef PACKER_DROP_COUNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_seq   = 0;
    m_gap   = 1'b0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " count"}, 32'(o_fifo_count), 32'(q.size()));
    chk({tag, " valid"}, 32'(o_out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, " data"}, o_out_data, q[0]);
    chk({tag, " overflow"}, 32'(o_overflow), 32'(m_ovf));
    chk({tag, " drops"}, 32'(o_drop_count), 32'(exp_drops()));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input logic v, input logic [13:0] a, input logic [13:0] b,
                      input logic cap, input logic clr, input logic rdy, input string tag);
    bit rd;
    bit strobe;
    i_data_valid_in = v;
    i_data_in_a     = a;
    i_data_in_b     = b;
    i_capture_en    = cap;
    i_clear         = clr;
    i_out_ready     = rdy;
    @(posedge clk);
    if (clr) begin
      model_reset();
    end else begin
      rd     = (q.size() != 0) && rdy;
      strobe = v && cap;
      if (rd) void'(q.pop_front());
      if (strobe && (q.size() < 16)) begin
        q.push_back({2'(m_seq), a, 1'b1, m_gap, b});
        m_seq = (m_seq + 1) % 4;
        m_gap = 1'b0;
      end else if (strobe) begin
        m_ovf   = 1'b1;
        m_gap   = 1'b1;
        m_drops = (m_drops < 65535) ? m_drops + 1 : 65535;
      end
    end
    #1;
    check_state(tag);
  endtask

  task automatic strobe(input logic rdy, input string tag);
    step(1'b1, 14'($urandom), 14'($urandom), 1'b1, 1'b0, rdy, tag);
  endtask

  task automatic idle(input logic rdy, input string tag);
    step(1'b0, 14'd0, 14'd0, 1'b1, 1'b0, rdy, tag);
  endtask

  initial begin
    int saved_drops;
    i_reset = 1'b1;
    i_data_in_a = '0; i_data_in_b = '0; i_data_valid_in = 1'b0;
    i_capture_en = 1'b0; i_clear = 1'b0; i_out_ready = 1'b0;
    model_reset();

    #12;
    chk("reset count", 32'(o_fifo_count), 32'd0);
    chk("reset valid", 32'(o_out_valid), 32'd0);
    chk("reset data", o_out_data, 32'd0);
    chk("reset overflow", 32'(o_overflow), 32'd0);
    chk("reset drops", 32'(o_drop_count), 32'd0);
    @(negedge clk);
    i_reset = 1'b0;

    // First word layout and fall-through latency.
    step(1'b1, 14'h1ABC, 14'h0123, 1'b1, 1'b0, 1'b0, "first");
    chk("first word", o_out_data, 32'h1ABC8123);
    idle(1'b1, "drain first");

    // Capture disabled: strobe ignored and not a drop.
    step(1'b1, 14'h0055, 14'h0066, 1'b0, 1'b0, 1'b1, "cap off");

    // Sequence numbering with a streaming consumer.
    step(1'b0, 14'd0, 14'd0, 1'b1, 1'b1, 1'b0, "clear seq");
    for (int i = 0; i < 5; i++) begin
      strobe(1'b1, "stream");
      chk("stream seq", 32'(o_out_data[31:30]), 32'(i % 4));
      chk("stream gap", 32'(o_out_data[14]), 32'd0);
    end
    idle(1'b1, "stream drain");

    // Overflow: 18 strobes into an unread FIFO.
    step(1'b0, 14'd0, 14'd0, 1'b1, 1'b1, 1'b0, "clear ovf");
    for (int i = 0; i < 18; i++) strobe(1'b0, "fill18");
    chk("ovf count", 32'(o_fifo_count), 32'd16);
    chk("ovf flag", 32'(o_overflow), 32'd1);
`ifdef PACKER_DROP_COUNT_EN
    chk("ovf drops", 32'(o_drop_count), 32'd2);
`else
    chk("ovf drops", 32'(o_drop_count), 32'd0);
`endif
    idle(1'b1, "pop one");
    strobe(1'b0, "after gap");
    for (int i = 0; i < 15; i++) idle(1'b1, "drain16");
    chk("gap word marker", 32'(o_out_data[14]), 32'd1);
    chk("gap word seq", 32'(o_out_data[31:30]), 32'd0);
    idle(1'b1, "drain last");
    chk("drained count", 32'(o_fifo_count), 32'd0);

    // Full FIFO with simultaneous read and write.
    step(1'b0, 14'd0, 14'd0, 1'b1, 1'b1, 1'b0, "clear full");
    for (int i = 0; i < 17; i++) strobe(1'b0, "fill17");
    saved_drops = int'(o_drop_count);
    strobe(1'b1, "full rw");
    chk("full rw count", 32'(o_fifo_count), 32'd16);
    chk("full rw drops", 32'(o_drop_count), 32'(saved_drops));

    // Clear beats a simultaneous strobe.
    step(1'b0, 14'd0, 14'd0, 1'b1, 1'b1, 1'b0, "clear5");
    for (int i = 0; i < 5; i++) strobe(1'b0, "fill5");
    step(1'b1, 14'h0AAA, 14'h1555, 1'b1, 1'b1, 1'b0, "clear+strobe");
    chk("clear count", 32'(o_fifo_count), 32'd0);
    chk("clear valid", 32'(o_out_valid), 32'd0);

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 9; i++) strobe(1'b0, "fill9");
    #2;
    i_reset = 1'b1;
    #1;
    chk("async count", 32'(o_fifo_count), 32'd0);
    chk("async valid", 32'(o_out_valid), 32'd0);
    chk("async data", o_out_data, 32'd0);
    chk("async overflow", 32'(o_overflow), 32'd0);
    chk("async drops", 32'(o_drop_count), 32'd0);
    i_reset = 1'b0;
    model_reset();
    strobe(1'b0, "post reset");
    chk("post reset seq", 32'(o_out_data[31:30]), 32'd0);
    chk("post reset gap", 32'(o_out_data[14]), 32'd0);

    // Randomized traffic, alternating slow and fast consumer phases.
    for (int c = 0; c < 400; c++) begin
      logic v, cap, clr, rdy;
      v   = ($urandom_range(0, 99) < 70);
      cap = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 2);
      rdy = (((c / 50) % 2) == 1) ? ($urandom_range(0, 99) < 80) : ($urandom_range(0, 99) < 20);
      step(v, 14'($urandom), 14'($urandom), cap, clr, rdy, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
